// File: rtl/tour_cmd_sequencer.sv
// Plays a pre-loaded knight's-tour move list out as RemoteComm commands, two legs per move.
// Optional feature: define SEQ_CAL_EN to issue a calibrate command (16'h0000) before move 0.
module tour_cmd_sequencer #(
    parameter int          MAX_MOVES  = 24,
    parameter int          TMO_CYCLES = 10_000_000,
    parameter logic [7:0]  RESP_ACK   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mv_wr,
    input  logic [4:0]  mv_addr,
    input  logic [2:0]  mv_data,
    input  logic [4:0]  num_moves,
    input  logic        start,
    input  logic        abort,
    output logic [15:0] cmd,
    output logic        snd_cmd,
    input  logic        cmd_snt,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [4:0]  cur_move
);

    typedef enum logic [3:0] {
        IDLE,
`ifdef SEQ_CAL_EN
        CAL_SEND,
        CAL_XMIT,
        CAL_WAIT,
`endif
        LEG1_SEND,
        LEG1_XMIT,
        LEG1_WAIT,
        LEG2_SEND,
        LEG2_XMIT,
        LEG2_WAIT,
        NEXT,
        DONE,
        ERR
    } state_t;

`ifdef SEQ_CAL_EN
    localparam state_t FIRST_SEND = CAL_SEND;
`else
    localparam state_t FIRST_SEND = LEG1_SEND;
`endif

    localparam logic [23:0] TMO_LAST  = 24'(TMO_CYCLES - 1);
    localparam logic [4:0]  MAX_COUNT = 5'(MAX_MOVES);

    state_t      state_q, state_d;
    logic [15:0] cmd_q, cmd_d;
    logic        snd_cmd_q, snd_cmd_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [4:0]  cur_move_q, cur_move_d;
    logic [4:0]  count_q, count_d;
    logic [23:0] tmo_q, tmo_d;
    logic [2:0]  move_mem [MAX_MOVES];
    logic [2:0]  cur_code;
    logic        tmo_hit;

    // Vertical leg is a plain move, horizontal leg a move with fanfare.
    function automatic logic [15:0] leg_cmd(input logic [2:0] code, input logic second);
        logic north, east, v_two;
        north = (code == 3'd0) || (code == 3'd1) || (code == 3'd6) || (code == 3'd7);
        east  = (code < 3'd4);
        v_two = (code == 3'd0) || (code == 3'd3) || (code == 3'd4) || (code == 3'd7);
        if (!second)
            leg_cmd = {4'h2, (north ? 8'h00 : 8'h7F), (v_two ? 4'd2 : 4'd1)};
        else
            leg_cmd = {4'h3, (east ? 8'hBF : 8'h3F), (v_two ? 4'd1 : 4'd2)};
    endfunction

    always_ff @(posedge clk) begin
        if (mv_wr && (state_q == IDLE) && (mv_addr < MAX_COUNT))
            move_mem[mv_addr] <= mv_data;
    end

    assign cur_code = move_mem[cur_move_q];
    assign tmo_hit  = (tmo_q == TMO_LAST);
    assign busy     = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        snd_cmd_d  = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
        cur_move_d = cur_move_q;
        count_d    = count_q;
        tmo_d      = tmo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d    = (num_moves > MAX_COUNT) ? MAX_COUNT : num_moves;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    cur_move_d = 5'd0;
                    if (num_moves == 5'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FIRST_SEND;
                    end
                end
            end
`ifdef SEQ_CAL_EN
            CAL_SEND: begin
                cmd_d     = 16'h0000;
                snd_cmd_d = 1'b1;
                tmo_d     = 24'd0;
                state_d   = CAL_XMIT;
            end
            CAL_XMIT: begin
                tmo_d = tmo_q + 24'd1;
                if (tmo_hit) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else if (cmd_snt) state_d = CAL_WAIT;
            end
            CAL_WAIT: begin
                tmo_d = tmo_q + 24'd1;
                if (resp_rdy) begin
                    state_d = (resp == RESP_ACK) ? LEG1_SEND : ERR;
                    err_d   = (resp != RESP_ACK);
                end else if (tmo_hit) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
`endif
            LEG1_SEND: begin
                cmd_d     = leg_cmd(cur_code, 1'b0);
                snd_cmd_d = 1'b1;
                tmo_d     = 24'd0;
                state_d   = LEG1_XMIT;
            end
            LEG1_XMIT: begin
                tmo_d = tmo_q + 24'd1;
                if (tmo_hit) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else if (cmd_snt) state_d = LEG1_WAIT;
            end
            LEG1_WAIT: begin
                tmo_d = tmo_q + 24'd1;
                if (resp_rdy) begin
                    state_d = (resp == RESP_ACK) ? LEG2_SEND : ERR;
                    err_d   = (resp != RESP_ACK);
                end else if (tmo_hit) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            LEG2_SEND: begin
                cmd_d     = leg_cmd(cur_code, 1'b1);
                snd_cmd_d = 1'b1;
                tmo_d     = 24'd0;
                state_d   = LEG2_XMIT;
            end
            LEG2_XMIT: begin
                tmo_d = tmo_q + 24'd1;
                if (tmo_hit) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else if (cmd_snt) state_d = LEG2_WAIT;
            end
            LEG2_WAIT: begin
                tmo_d = tmo_q + 24'd1;
                if (resp_rdy) begin
                    state_d = (resp == RESP_ACK) ? NEXT : ERR;
                    err_d   = (resp != RESP_ACK);
                end else if (tmo_hit) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            NEXT: begin
                cur_move_d = cur_move_q + 5'd1;
                if ((cur_move_q + 5'd1) == count_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = LEG1_SEND;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides everything else, including a response arriving in the same cycle.
        if (abort && busy) begin
            state_d    = IDLE;
            snd_cmd_d  = 1'b0;
            cmd_d      = cmd_q;
            done_d     = done_q;
            err_d      = err_q;
            cur_move_d = cur_move_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_q      <= 16'h0000;
            snd_cmd_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cur_move_q <= 5'd0;
            count_q    <= 5'd0;
            tmo_q      <= 24'd0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            snd_cmd_q  <= snd_cmd_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cur_move_q <= cur_move_d;
            count_q    <= count_d;
            tmo_q      <= tmo_d;
        end
    end

    assign cmd      = cmd_q;
    assign snd_cmd  = snd_cmd_q;
    assign done     = done_q;
    assign err      = err_q;
    assign cur_move = cur_move_q;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Scoreboard bench for tour_cmd_sequencer: expected commands queued at start, checked on each snd_cmd.
module tb_tour_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mv_wr = 1'b0;
    logic [4:0]  mv_addr = '0;
    logic [2:0]  mv_data = '0;
    logic [4:0]  num_moves = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt = 1'b0;
    logic        resp_rdy = 1'b0;
    logic [7:0]  resp = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  cur_move;

`ifdef SEQ_CAL_EN
    localparam int CAL = 1;
`else
    localparam int CAL = 0;
`endif

    int          n_tests = 0;
    int          n_fail = 0;
    int          snd_count = 0;
    int          snap;
    bit          ok;
    logic [15:0] exp_q[$];
    logic [2:0]  tb_mem [24];

    tour_cmd_sequencer #(.TMO_CYCLES(1000)) dut (
        .clk(clk), .rst(rst), .mv_wr(mv_wr), .mv_addr(mv_addr), .mv_data(mv_data),
        .num_moves(num_moves), .start(start), .abort(abort), .cmd(cmd), .snd_cmd(snd_cmd),
        .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done),
        .err(err), .cur_move(cur_move)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (snd_cmd === 1'b1) begin
            snd_count++;
            if (exp_q.size() == 0) check_val("sb_underflow", exp_q.size(), 32'd1);
            else                   check_val("cmd", {16'd0, cmd}, {16'd0, exp_q.pop_front()});
        end
    end

    function automatic logic [15:0] leg_exp(input logic [2:0] c, input bit second);
        case (c)
            3'd0: return second ? 16'h3BF1 : 16'h2002;
            3'd1: return second ? 16'h3BF2 : 16'h2001;
            3'd2: return second ? 16'h3BF2 : 16'h27F1;
            3'd3: return second ? 16'h3BF1 : 16'h27F2;
            3'd4: return second ? 16'h33F1 : 16'h27F2;
            3'd5: return second ? 16'h33F2 : 16'h27F1;
            3'd6: return second ? 16'h33F2 : 16'h2001;
            default: return second ? 16'h33F1 : 16'h2002;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_move(input int a, input int c);
        mv_wr = 1'b1;
        mv_addr = a[4:0];
        mv_data = c[2:0];
        tick();
        mv_wr = 1'b0;
        if (a < 24) tb_mem[a] = c[2:0];
    endtask

    task automatic start_tour(input int n, input bit with_abort);
        int cnt;
        cnt = (n > 24) ? 24 : n;
        if (CAL == 1 && cnt > 0) exp_q.push_back(16'h0000);
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back(leg_exp(tb_mem[i], 1'b0));
            exp_q.push_back(leg_exp(tb_mem[i], 1'b1));
        end
        num_moves = n[4:0];
        start = 1'b1;
        abort = with_abort;
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_snd(output bit found);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (snd_cmd === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check_val("snd_timeout", {31'd0, snd_cmd}, 32'd1);
    endtask

    // Plays RemoteComm for nlegs legs; stops after the leg given a bad reply.
    task automatic serve(input int nlegs, input int bad_idx, input logic [7:0] bad_resp,
                         input bit xmit_noise, input int start_leg);
        bit f;
        for (int k = 0; k < nlegs; k++) begin
            wait_snd(f);
            if (!f) return;
            tick();
            if (xmit_noise) begin
                resp_rdy = 1'b1;
                resp = 8'h5A;
            end
            tick();
            resp_rdy = 1'b0;
            cmd_snt = 1'b1;
            start = (k == start_leg);
            tick();
            cmd_snt = 1'b0;
            start = 1'b0;
            resp_rdy = 1'b1;
            resp = (k == bad_idx) ? bad_resp : 8'hA5;
            tick();
            resp_rdy = 1'b0;
            if (k == bad_idx) return;
        end
    endtask

    task automatic sb_flush(input int left);
        check_val("sb_left", exp_q.size(), left);
        exp_q.delete();
    endtask

    initial begin
        repeat (3) tick();
        check_val("rst_cmd", {16'd0, cmd}, 32'h0);
        check_val("rst_snd", {31'd0, snd_cmd}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_err", {31'd0, err}, 32'd0);
        check_val("rst_cur", {27'd0, cur_move}, 32'd0);
        rst = 1'b0;
        tick();

        // Single move, code 1
        load_move(0, 1);
        snap = snd_count;
        start_tour(1, 1'b0);
        serve(2 + CAL, -1, 8'h00, 1'b0, -1);
        repeat (3) tick();
        check_val("t1_done", {31'd0, done}, 32'd1);
        check_val("t1_err", {31'd0, err}, 32'd0);
        check_val("t1_cur", {27'd0, cur_move}, 32'd1);
        check_val("t1_busy", {31'd0, busy}, 32'd0);
        check_val("t1_snds", snd_count - snap, 2 + CAL);
        sb_flush(0);

        // Four moves; resp noise during XMIT, start while busy, abort together with start
        load_move(0, 0); load_move(1, 3); load_move(2, 4); load_move(3, 7);
        start_tour(4, 1'b1);
        serve(8 + CAL, -1, 8'h00, 1'b1, 3);
        repeat (3) tick();
        check_val("t2_done", {31'd0, done}, 32'd1);
        check_val("t2_err", {31'd0, err}, 32'd0);
        check_val("t2_cur", {27'd0, cur_move}, 32'd4);
        sb_flush(0);

        // Bad reply on leg2 of move 2
        start_tour(4, 1'b0);
        serve(8 + CAL, 5 + CAL, 8'h5A, 1'b0, -1);
        check_val("t3_err", {31'd0, err}, 32'd1);
        check_val("t3_done", {31'd0, done}, 32'd0);
        check_val("t3_busy", {31'd0, busy}, 32'd0);
        check_val("t3_cur", {27'd0, cur_move}, 32'd2);
        snap = snd_count;
        repeat (20) tick();
        check_val("t3_nosnd", snd_count - snap, 0);
        check_val("t3_err_sticky", {31'd0, err}, 32'd1);
        sb_flush(2);

        // Timeout; a write while busy is dropped, a write after is kept
        load_move(0, 2);
        start_tour(1, 1'b0);
        wait_snd(ok);
        mv_wr = 1'b1; mv_addr = 5'd0; mv_data = 3'd5;
        @(negedge clk);
        mv_wr = 1'b0;
        repeat (998) @(negedge clk);
        check_val("t4_err_999", {31'd0, err}, 32'd0);
        @(negedge clk);
        check_val("t4_err_1000", {31'd0, err}, 32'd1);
        sb_flush(1 + CAL);
        repeat (2) tick();
        load_move(1, 6);
        start_tour(2, 1'b0);
        serve(4 + CAL, -1, 8'h00, 1'b0, -1);
        repeat (3) tick();
        check_val("t4_done", {31'd0, done}, 32'd1);
        check_val("t4_cur", {27'd0, cur_move}, 32'd2);
        sb_flush(0);

        // Abort in LEG1_WAIT, late response ignored
        start_tour(1, 1'b0);
        serve(CAL, -1, 8'h00, 1'b0, -1);
        wait_snd(ok);
        tick();
        cmd_snt = 1'b1;
        tick();
        cmd_snt = 1'b0;
        abort = 1'b1;
        snap = snd_count;
        tick();
        abort = 1'b0;
        check_val("t5_busy", {31'd0, busy}, 32'd0);
        check_val("t5_snd", {31'd0, snd_cmd}, 32'd0);
        resp_rdy = 1'b1; resp = 8'hA5;
        tick();
        resp_rdy = 1'b0;
        repeat (5) tick();
        check_val("t5_done", {31'd0, done}, 32'd0);
        check_val("t5_err", {31'd0, err}, 32'd0);
        check_val("t5_busy2", {31'd0, busy}, 32'd0);
        check_val("t5_nosnd", snd_count - snap, 0);
        sb_flush(1);

        // Zero moves completes immediately
        snap = snd_count;
        start_tour(0, 1'b0);
        check_val("t6_done", {31'd0, done}, 32'd1);
        check_val("t6_busy", {31'd0, busy}, 32'd0);
        repeat (5) tick();
        check_val("t6_nosnd", snd_count - snap, 0);

        // Saturation: 31 requested, 24 played
        for (int i = 0; i < 24; i++) load_move(i, $urandom_range(0, 7));
        for (int i = 24; i < 32; i++) begin
            mv_wr = 1'b1; mv_addr = i[4:0]; mv_data = 3'd3;
            tick();
        end
        mv_wr = 1'b0;
        start_tour(31, 1'b0);
        serve(48 + CAL, -1, 8'h00, 1'b0, -1);
        repeat (3) tick();
        check_val("t7_done", {31'd0, done}, 32'd1);
        check_val("t7_cur", {27'd0, cur_move}, 32'd24);
        sb_flush(0);

        // Reset mid-tour
        start_tour(2, 1'b0);
        serve(2 + CAL, -1, 8'h00, 1'b0, -1);
        wait_snd(ok);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t8_cmd", {16'd0, cmd}, 32'h0);
        check_val("t8_snd", {31'd0, snd_cmd}, 32'd0);
        check_val("t8_busy", {31'd0, busy}, 32'd0);
        check_val("t8_done", {31'd0, done}, 32'd0);
        check_val("t8_err", {31'd0, err}, 32'd0);
        check_val("t8_cur", {27'd0, cur_move}, 32'd0);
        snap = snd_count;
        repeat (10) tick();
        check_val("t8_nosnd", snd_count - snap, 0);
        sb_flush(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "bench time limit");
    end

endmodule
